// File: rtl/regfile_pkg.sv
// Shared widths and the write-back entry type for the register-file write path.
// Pure declarations: no latency, no flow control.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;
endpackage

// File: rtl/regfile_writeback_buffer_if.sv
// Write-back request channel from the execute/load units into the buffer.
// Valid/ready: a request transfers on any rising edge with wb_valid & wb_ready.
interface regfile_writeback_buffer_if;
  import regfile_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  modport master (output wb_valid, output wb_rd, output wb_data, input wb_ready);
  modport slave  (input wb_valid, input wb_rd, input wb_data, output wb_ready);
endinterface

// File: rtl/wb_fifo.sv
// Circular-buffer FIFO with occupancy count; entries exported oldest-first for forwarding.
// One push and one pop per edge; caller guarantees no push when full or pop when empty.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  wb_entry_t        push_entry,
  input  logic             pop,
  output wb_entry_t        head_entry,
  output logic [CNT_W-1:0] count,
  output wb_entry_t        entries [DEPTH],
  output logic [DEPTH-1:0] valid
);
  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;

  // DEPTH is a power of two, so plain pointer overflow is the modulo wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop)  head <= head + 1'b1;
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= push_entry;
  end

  assign head_entry = mem[head];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      entries[i] = mem[head + PTR_W'(i)];
      valid[i]   = (CNT_W'(i) < count);
    end
  end
endmodule

// File: rtl/regfile_writeback_buffer.sv
// Buffers write-backs and drains one per cycle to the RF write port (2-edge min latency), with read bypass.
// wb_ready drops only when the FIFO holds DEPTH entries; rf_stall holds the drain, flush discards everything.
module regfile_writeback_buffer
  import regfile_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  regfile_writeback_buffer_if.slave  wb,
  input  logic                       rf_stall,
  input  logic                       flush,
  output logic                       RegWrite,
  output logic [ADDR_W-1:0]          Rd,
  output logic [DATA_W-1:0]          Write_data,
  input  logic [ADDR_W-1:0]          Rs1,
  input  logic [ADDR_W-1:0]          Rs2,
  output logic                       fwd1_hit,
  output logic [DATA_W-1:0]          fwd1_data,
  output logic                       fwd2_hit,
  output logic [DATA_W-1:0]          fwd2_data,
  output logic [CNT_W-1:0]           count
);
  logic             push;
  logic             pop;
  wb_entry_t        head_entry;
  wb_entry_t        entries [DEPTH];
  logic [DEPTH-1:0] valid;

  assign wb.wb_ready = (count != CNT_W'(DEPTH));
  // x0 requests still handshake but never occupy a slot.
  assign push = wb.wb_valid && wb.wb_ready && !flush && (wb.wb_rd != '0);
  assign pop  = (count != '0) && !rf_stall && !flush;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .push       (push),
    .push_entry ('{rd: wb.wb_rd, data: wb.wb_data}),
    .pop        (pop),
    .head_entry (head_entry),
    .count      (count),
    .entries    (entries),
    .valid      (valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RegWrite   <= 1'b0;
      Rd         <= '0;
      Write_data <= '0;
    end else begin
      RegWrite <= pop;
      if (pop) begin
        Rd         <= head_entry.rd;
        Write_data <= head_entry.data;
      end
    end
  end

  // Scan oldest to newest so the newest matching entry is the one left standing.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_hit  = 1'b0;
    fwd2_data = '0;
    if (RegWrite && Rd == Rs1 && Rs1 != '0) begin
      fwd1_hit  = 1'b1;
      fwd1_data = Write_data;
    end
    if (RegWrite && Rd == Rs2 && Rs2 != '0) begin
      fwd2_hit  = 1'b1;
      fwd2_data = Write_data;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (valid[i] && entries[i].rd == Rs1 && Rs1 != '0) begin
        fwd1_hit  = 1'b1;
        fwd1_data = entries[i].data;
      end
      if (valid[i] && entries[i].rd == Rs2 && Rs2 != '0) begin
        fwd2_hit  = 1'b1;
        fwd2_data = entries[i].data;
      end
    end
  end
endmodule

// File: tb/tb_regfile_writeback_buffer.sv
// Bench for regfile_writeback_buffer: vector table, corner sequences, then random traffic vs a queue model.
module tb_regfile_writeback_buffer;
  import regfile_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              rf_stall;
  logic              flush;
  logic              RegWrite;
  logic [ADDR_W-1:0] Rd;
  logic [DATA_W-1:0] Write_data;
  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic              fwd1_hit;
  logic              fwd2_hit;
  logic [DATA_W-1:0] fwd1_data;
  logic [DATA_W-1:0] fwd2_data;
  logic [CNT_W-1:0]  count;

  int total = 0;
  int bad   = 0;

  regfile_writeback_buffer_if wbi ();

  regfile_writeback_buffer #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .wb         (wbi),
    .rf_stall   (rf_stall),
    .flush      (flush),
    .RegWrite   (RegWrite),
    .Rd         (Rd),
    .Write_data (Write_data),
    .Rs1        (Rs1),
    .Rs2        (Rs2),
    .fwd1_hit   (fwd1_hit),
    .fwd1_data  (fwd1_data),
    .fwd2_hit   (fwd2_hit),
    .fwd2_data  (fwd2_data),
    .count      (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic              v;
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] d;
    logic              st;
    logic [ADDR_W-1:0] rs1, rs2;
    logic              e_rdy, e_we;
    logic [ADDR_W-1:0] e_rd;
    logic [DATA_W-1:0] e_wd;
    logic [CNT_W-1:0]  e_cnt;
    logic              e_h1;
    logic [DATA_W-1:0] e_d1;
    logic              e_h2;
    logic [DATA_W-1:0] e_d2;
  } vec_t;

  function automatic vec_t mk(input logic v, input int rd, input logic [31:0] d, input logic st,
                              input int rs1, input int rs2, input logic e_rdy, input logic e_we,
                              input int e_rd, input logic [31:0] e_wd, input int e_cnt,
                              input logic e_h1, input logic [31:0] e_d1,
                              input logic e_h2, input logic [31:0] e_d2);
    vec_t r;
    r.v = v; r.rd = ADDR_W'(rd); r.d = d; r.st = st;
    r.rs1 = ADDR_W'(rs1); r.rs2 = ADDR_W'(rs2);
    r.e_rdy = e_rdy; r.e_we = e_we; r.e_rd = ADDR_W'(e_rd); r.e_wd = e_wd;
    r.e_cnt = CNT_W'(e_cnt); r.e_h1 = e_h1; r.e_d1 = e_d1; r.e_h2 = e_h2; r.e_d2 = e_d2;
    return r;
  endfunction

  // Reference model: pending writes in acceptance order plus the RF port register.
  wb_entry_t         mq[$];
  logic              m_we;
  logic [ADDR_W-1:0] m_rd;
  logic [DATA_W-1:0] m_wd;

  function automatic void model_fwd(input logic [ADDR_W-1:0] rs, output logic h, output logic [DATA_W-1:0] d);
    h = 1'b0;
    d = '0;
    if (rs != '0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!h && mq[i].rd == rs) begin
          h = 1'b1;
          d = mq[i].data;
        end
      end
      if (!h && m_we && m_rd == rs) begin
        h = 1'b1;
        d = m_wd;
      end
    end
  endfunction

  localparam logic [31:0] DB = 32'hDEADBEEF;
  vec_t vt [19];

  initial begin
    logic              eh;
    logic [DATA_W-1:0] ed;
    logic              acc;
    logic              do_pop;

    vt[0]  = mk(1, 5, DB,    0, 5, 0, 1, 0, 0, 0,     0, 0, 0,     0, 0);
    vt[1]  = mk(0, 0, 0,     0, 5, 0, 1, 0, 0, 0,     1, 1, DB,    0, 0);
    vt[2]  = mk(0, 0, 0,     0, 5, 0, 1, 1, 5, DB,    0, 1, DB,    0, 0);
    vt[3]  = mk(0, 0, 0,     0, 5, 0, 1, 0, 5, DB,    0, 0, 0,     0, 0);
    vt[4]  = mk(1, 1, 'h101, 1, 0, 0, 1, 0, 5, DB,    0, 0, 0,     0, 0);
    vt[5]  = mk(1, 2, 'h102, 1, 1, 0, 1, 0, 5, DB,    1, 1, 'h101, 0, 0);
    vt[6]  = mk(1, 3, 'h103, 1, 0, 0, 1, 0, 5, DB,    2, 0, 0,     0, 0);
    vt[7]  = mk(1, 4, 'h104, 1, 0, 0, 1, 0, 5, DB,    3, 0, 0,     0, 0);
    vt[8]  = mk(1, 5, 'h105, 1, 2, 5, 0, 0, 5, DB,    4, 1, 'h102, 0, 0);
    vt[9]  = mk(1, 5, 'h105, 0, 4, 0, 0, 0, 5, DB,    4, 1, 'h104, 0, 0);
    vt[10] = mk(1, 5, 'h105, 0, 1, 5, 1, 1, 1, 'h101, 3, 1, 'h101, 0, 0);
    vt[11] = mk(0, 0, 0,     0, 5, 2, 1, 1, 2, 'h102, 3, 1, 'h105, 1, 'h102);
    vt[12] = mk(0, 0, 0,     0, 0, 0, 1, 1, 3, 'h103, 2, 0, 0,     0, 0);
    vt[13] = mk(0, 0, 0,     0, 0, 0, 1, 1, 4, 'h104, 1, 0, 0,     0, 0);
    vt[14] = mk(0, 0, 0,     0, 5, 0, 1, 1, 5, 'h105, 0, 1, 'h105, 0, 0);
    vt[15] = mk(0, 0, 0,     0, 0, 0, 1, 0, 5, 'h105, 0, 0, 0,     0, 0);
    vt[16] = mk(1, 0, 'h1234, 0, 0, 0, 1, 0, 5, 'h105, 0, 0, 0,    0, 0);
    vt[17] = mk(0, 0, 0,     0, 0, 0, 1, 0, 5, 'h105, 0, 0, 0,     0, 0);
    vt[18] = mk(0, 0, 0,     0, 0, 0, 1, 0, 5, 'h105, 0, 0, 0,     0, 0);

    rst_n = 1'b0; rf_stall = 1'b0; flush = 1'b0;
    wbi.wb_valid = 1'b0; wbi.wb_rd = '0; wbi.wb_data = '0;
    Rs1 = 5'd3; Rs2 = 5'd4;
    #3;
    chk("reset_regwrite", RegWrite, 0);
    chk("reset_rd", Rd, 0);
    chk("reset_wdata", Write_data, 0);
    chk("reset_count", count, 0);
    chk("reset_ready", wbi.wb_ready, 1);
    chk("reset_hit1", fwd1_hit, 0);
    chk("reset_hit2", fwd2_hit, 0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      wbi.wb_valid = vt[i].v; wbi.wb_rd = vt[i].rd; wbi.wb_data = vt[i].d;
      rf_stall = vt[i].st; Rs1 = vt[i].rs1; Rs2 = vt[i].rs2;
      #1;
      chk($sformatf("vec%0d_ready", i), wbi.wb_ready, vt[i].e_rdy);
      chk($sformatf("vec%0d_we", i), RegWrite, vt[i].e_we);
      chk($sformatf("vec%0d_rd", i), Rd, vt[i].e_rd);
      chk($sformatf("vec%0d_wdata", i), Write_data, vt[i].e_wd);
      chk($sformatf("vec%0d_count", i), count, vt[i].e_cnt);
      chk($sformatf("vec%0d_hit1", i), fwd1_hit, vt[i].e_h1);
      chk($sformatf("vec%0d_data1", i), fwd1_data, vt[i].e_d1);
      chk($sformatf("vec%0d_hit2", i), fwd2_hit, vt[i].e_h2);
      chk($sformatf("vec%0d_data2", i), fwd2_data, vt[i].e_d2);
      tick();
    end

    // Two pending writes to the same register: newest forwarded, both drained in order.
    rf_stall = 1'b1;
    wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd7; wbi.wb_data = 32'h1;
    tick();
    wbi.wb_data = 32'h2;
    tick();
    wbi.wb_valid = 1'b0; Rs1 = 5'd7; Rs2 = 5'd8;
    #1;
    chk("same_rd_count", count, 2);
    chk("same_rd_hit1", fwd1_hit, 1);
    chk("same_rd_data1", fwd1_data, 32'h2);
    chk("same_rd_hit2", fwd2_hit, 0);
    rf_stall = 1'b0;
    tick();
    chk("same_rd_first_we", RegWrite, 1);
    chk("same_rd_first_rd", Rd, 7);
    chk("same_rd_first_wd", Write_data, 32'h1);
    chk("same_rd_mid_data1", fwd1_data, 32'h2);
    tick();
    chk("same_rd_second_we", RegWrite, 1);
    chk("same_rd_second_wd", Write_data, 32'h2);
    tick();
    chk("same_rd_done_we", RegWrite, 0);
    chk("same_rd_done_count", count, 0);

    // Flush with three pending and a simultaneous request.
    rf_stall = 1'b1;
    wbi.wb_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wbi.wb_rd = ADDR_W'(10 + i); wbi.wb_data = 32'hF00 + i;
      tick();
    end
    flush = 1'b1; wbi.wb_rd = 5'd13; wbi.wb_data = 32'hAA;
    #1;
    chk("flush_ready", wbi.wb_ready, 1);
    chk("flush_pre_count", count, 3);
    tick();
    flush = 1'b0; wbi.wb_valid = 1'b0; rf_stall = 1'b0; Rs1 = 5'd13; Rs2 = 5'd10;
    #1;
    chk("flush_count", count, 0);
    chk("flush_hit1", fwd1_hit, 0);
    chk("flush_hit2", fwd2_hit, 0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("flush_we%0d", i), RegWrite, 0);
      tick();
    end

    // Reset mid-drain with one more entry still queued.
    wbi.wb_valid = 1'b1; wbi.wb_rd = 5'd9; wbi.wb_data = 32'h99;
    tick();
    wbi.wb_rd = 5'd20; wbi.wb_data = 32'h20;
    tick();
    wbi.wb_valid = 1'b0; rf_stall = 1'b1; Rs1 = 5'd9; Rs2 = 5'd20;
    #1;
    chk("rst_pre_we", RegWrite, 1);
    chk("rst_pre_count", count, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_we", RegWrite, 0);
    chk("rst_mid_count", count, 0);
    chk("rst_mid_hit1", fwd1_hit, 0);
    chk("rst_mid_hit2", fwd2_hit, 0);
    chk("rst_mid_ready", wbi.wb_ready, 1);
    tick();
    rst_n = 1'b1; rf_stall = 1'b0;

    // Random traffic against the queue model, starting from reset state.
    m_we = 1'b0; m_rd = '0; m_wd = '0;
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      wbi.wb_valid = ($urandom_range(0, 9) < 7);
      wbi.wb_rd    = ADDR_W'($urandom_range(0, 7));
      wbi.wb_data  = $urandom;
      rf_stall     = ($urandom_range(0, 9) < 3);
      flush        = ($urandom_range(0, 39) == 0);
      Rs1          = ADDR_W'($urandom_range(0, 7));
      Rs2          = ADDR_W'($urandom_range(0, 7));
      #1;
      chk("rnd_ready", wbi.wb_ready, mq.size() != DEPTH);
      chk("rnd_count", count, mq.size());
      chk("rnd_we", RegWrite, m_we);
      chk("rnd_rd", Rd, m_rd);
      chk("rnd_wdata", Write_data, m_wd);
      model_fwd(Rs1, eh, ed);
      chk("rnd_hit1", fwd1_hit, eh);
      chk("rnd_data1", fwd1_data, ed);
      model_fwd(Rs2, eh, ed);
      chk("rnd_hit2", fwd2_hit, eh);
      chk("rnd_data2", fwd2_data, ed);
      @(posedge clk);
      acc    = wbi.wb_valid && (mq.size() != DEPTH);
      do_pop = (mq.size() != 0) && !rf_stall && !flush;
      if (flush) begin
        mq.delete();
        m_we = 1'b0;
      end else begin
        m_we = do_pop;
        if (do_pop) begin
          m_rd = mq[0].rd;
          m_wd = mq[0].data;
          void'(mq.pop_front());
        end
        if (acc && wbi.wb_rd != '0) mq.push_back('{rd: wbi.wb_rd, data: wbi.wb_data});
      end
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
